gate_count_tx: RTL and testbench

Parametrised gated cycle counter with a buffered serial transmitter.
- Synchronises an external gate and counts clk cycles while the gate is high.
- Snapshots the count and overflow flag at gate fall, then shifts the frame out MSB-first on a divided bit clock.
- A one-deep pending buffer with overrun detection decouples measurement from transmission.
- Sits between the fast-clock measurement domain and the low-speed serial/LED outputs.

---
 rtl/gate_count_tx_if.sv | 27 ++
 rtl/gate_count_tx.sv | 184 ++++++++++++++++++
 tb/tb_gate_count_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_count_tx_if.sv
// Pin bundle between the gated counter/transmitter and its surroundings.
// Latency: none, wires only.
// Backpressure: none; the serial side is free-running and the gate is never throttled.
interface gate_count_tx_if #(
  parameter int LED_BITS = 8
);
  logic                ena;
  logic                serout;
  logic                sclk;
  logic                frame_act;
  logic                busy;
  logic                done;
  logic                overrun;
  logic [LED_BITS-1:0] leds;

  // Environment side: drives the gate and observes the serial/LED outputs.
  modport master (
    output ena,
    input  serout, sclk, frame_act, busy, done, overrun, leds
  );

  // Design side.
  modport slave (
    input  ena,
    output serout, sclk, frame_act, busy, done, overrun, leds
  );
endinterface

// File: rtl/gate_count_tx.sv
// Gated cycle counter whose result is serialised MSB-first as {ovf, count} on a divided bit clock.
// Latency: ena fall to snapshot SYNC_STAGES+1 cycles; snapshot to LOAD 1 cycle when idle; frame 1+(WIDTH+2)*2*DIV cycles.
// Backpressure: none; a one-deep pending slot buffers one snapshot, a newer one overwrites it and sets sticky overrun.
module gate_count_tx #(
  parameter int WIDTH       = 31,
  parameter int DIV         = 5000,
  parameter int SYNC_STAGES = 2,
  parameter int LED_BITS    = 8
) (
  input logic           clk,
  input logic           reset,
  gate_count_tx_if.slave bus
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [TW-1:0]    TLAST = TW'(DIV - 1);
  localparam logic [WIDTH-1:0] CMAX  = '1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sync;
  logic                   gate_s, gate_d, rise, fall;
  logic [WIDTH-1:0]       count;
  logic                   ovf;
  logic [WIDTH:0]         snap;
  logic                   pending;
  logic                   overrun_q;
  logic [LED_BITS-1:0]    leds_q;
  logic [WIDTH:0]         shreg;
  logic [BW-1:0]          bitcnt;
  logic [TW-1:0]          timer;
  logic                   half;
  logic                   tick;
  logic                   serout_c, sclk_c, frame_c, busy_c, done_c;

  assign gate_s = sync[SYNC_STAGES-1];
  assign rise   = gate_s & ~gate_d;
  assign fall   = ~gate_s & gate_d;
  assign tick   = (timer == TLAST);

  // Bring the asynchronous gate into clk and keep a delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      gate_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus.ena};
      gate_d <= gate_s;
    end
  end

  // Saturating count of cycles with the synchronised gate high; the rise cycle counts as the first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (rise) begin
      count <= WIDTH'(1);
      ovf   <= 1'b0;
    end else if (gate_s) begin
      if (count == CMAX) ovf   <= 1'b1;
      else               count <= count + WIDTH'(1);
    end
  end

  // Snapshot at gate fall into the pending slot; overwriting an unconsumed snapshot is an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap      <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      leds_q    <= '0;
    end else begin
      if (fall) begin
        snap    <= {ovf, count};
        leds_q  <= count[WIDTH-1 -: LED_BITS];
        pending <= 1'b1;
        // LOAD consumes the slot in this same cycle, so refilling it then is not an overrun.
        if (pending && state != LOAD) overrun_q <= 1'b1;
      end else if (state == LOAD) begin
        pending <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Shift register, bit counter and half-period timer; timer and phase restart on entry to SHIFT and GAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      timer  <= '0;
      half   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          shreg  <= snap;
          bitcnt <= BW'(WIDTH);
          timer  <= '0;
          half   <= 1'b0;
        end
        SHIFT: begin
          if (tick) begin
            timer <= '0;
            if (!half) begin
              half <= 1'b1;
            end else begin
              half <= 1'b0;
              if (bitcnt != '0) begin
                shreg  <= {shreg[WIDTH-1:0], 1'b0};
                bitcnt <= bitcnt - BW'(1);
              end
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GAP: begin
          if (tick) begin
            timer <= '0;
            half  <= ~half;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          timer <= '0;
          half  <= 1'b0;
        end
      endcase
    end
  end

  // Next state and Moore-style serial outputs.
  always_comb begin
    next_state = state;
    serout_c   = 1'b0;
    sclk_c     = 1'b0;
    frame_c    = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (pending) next_state = LOAD;
      end
      LOAD: begin
        busy_c     = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        busy_c   = 1'b1;
        frame_c  = 1'b1;
        serout_c = shreg[WIDTH];
        sclk_c   = half;
        if (tick && half && bitcnt == '0) next_state = GAP;
      end
      GAP: begin
        busy_c = 1'b1;
        if (tick && half) begin
          done_c     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.serout    = serout_c;
  assign bus.sclk      = sclk_c;
  assign bus.frame_act = frame_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.overrun   = overrun_q;
  assign bus.leds      = leds_q;

endmodule

// File: tb/tb_gate_count_tx.sv
// Directed bench for gate_count_tx with WIDTH=8, DIV=2, SYNC_STAGES=2, LED_BITS=8.
// Latency: a 1-cycle gate yields a 41-cycle frame (LOAD + 9 bits * 4 + gap 4).
// Backpressure: none; frames are observed by sampling the pins on the falling clock edge.
module tb_gate_count_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  gate_count_tx_if #(.LED_BITS(8)) bus ();

  gate_count_tx #(
    .WIDTH(8), .DIV(2), .SYNC_STAGES(2), .LED_BITS(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Hold ena high for exactly n rising edges, driven just after an edge.
  task automatic pulse_gate(input int n);
    @(posedge clk); #1 bus.ena = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.ena = 1'b0;
  endtask

  // Wait (bounded) for busy, then record one frame: bits at sclk rises, busy length, done pulses.
  task automatic recv_frame(output logic [8:0] fr, output int nb, output int len, output int nd,
                            output int fa, output bit spacing_ok, output bit to, output int wt);
    int   last;
    logic prev_sclk;
    last = -1; prev_sclk = 1'b0;
    fr = '0; nb = 0; len = 0; nd = 0; fa = 0; spacing_ok = 1'b1; to = 1'b0; wt = 0;
    do begin
      @(negedge clk);
      wt++;
    end while (!bus.busy && wt < 2000);
    if (!bus.busy) begin
      to = 1'b1;
    end else begin
      while (bus.busy && len < 200) begin
        if (bus.sclk && !prev_sclk) begin
          fr = {fr[7:0], bus.serout};
          nb++;
          if (last >= 0 && len - last != 4) spacing_ok = 1'b0;
          last = len;
        end
        if (bus.done) nd++;
        if (bus.frame_act) fa++;
        prev_sclk = bus.sclk;
        len++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.ena = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 bus.ena = ~bus.ena;
    end
    @(negedge clk);
    if ({bus.serout, bus.sclk, bus.frame_act, bus.busy, bus.done, bus.overrun, bus.leds} !== 15'h0) begin
      $display("FAIL reset_hold outputs=%h expected=0",
               {bus.serout, bus.sclk, bus.frame_act, bus.busy, bus.done, bus.overrun, bus.leds});
      failures++;
    end
    checks++;
    @(posedge clk); #1 reset = 1'b0; bus.ena = 1'b0;
    repeat (10) @(negedge clk);
    if ({bus.serout, bus.sclk, bus.frame_act, bus.busy, bus.done, bus.overrun, bus.leds} !== 15'h0) begin
      $display("FAIL reset_release outputs=%h expected=0",
               {bus.serout, bus.sclk, bus.frame_act, bus.busy, bus.done, bus.overrun, bus.leds});
      failures++;
    end
    checks++;
  endtask

  task automatic test_single_gate;
    logic [8:0] fr;
    int nb, len, nd, fa, wt;
    bit sp, to;
    pulse_gate(5);
    recv_frame(fr, nb, len, nd, fa, sp, to, wt);
    if (to !== 1'b0) begin $display("FAIL single_timeout got=%0d expected=0", to); failures++; end
    checks++;
    if (fr !== 9'h005) begin $display("FAIL single_frame got=%h expected=005", fr); failures++; end
    checks++;
    if (nb !== 9) begin $display("FAIL single_bits got=%0d expected=9", nb); failures++; end
    checks++;
    if (sp !== 1'b1) begin $display("FAIL single_sclk_spacing got=%0d expected=1", sp); failures++; end
    checks++;
    if (len !== 41) begin $display("FAIL single_len got=%0d expected=41", len); failures++; end
    checks++;
    if (fa !== 36) begin $display("FAIL single_frame_act got=%0d expected=36", fa); failures++; end
    checks++;
    if (nd !== 1) begin $display("FAIL single_done got=%0d expected=1", nd); failures++; end
    checks++;
    if (bus.leds !== 8'h05) begin $display("FAIL single_leds got=%h expected=05", bus.leds); failures++; end
    checks++;
    if (bus.busy !== 1'b0) begin $display("FAIL single_idle_busy got=%b expected=0", bus.busy); failures++; end
    checks++;
  endtask

  task automatic test_saturation;
    logic [8:0] fr;
    int nb, len, nd, fa, wt;
    bit sp, to;
    pulse_gate(300);
    recv_frame(fr, nb, len, nd, fa, sp, to, wt);
    if (fr !== 9'h1FF || to !== 1'b0) begin
      $display("FAIL sat_frame got=%h timeout=%0d expected=1ff", fr, to); failures++;
    end
    checks++;
    if (bus.leds !== 8'hFF) begin $display("FAIL sat_leds got=%h expected=ff", bus.leds); failures++; end
    checks++;
    if (bus.overrun !== 1'b0) begin $display("FAIL sat_overrun got=%b expected=0", bus.overrun); failures++; end
    checks++;
  endtask

  task automatic test_overrun;
    logic [8:0] fr1, fr2;
    int nb1, len1, nd1, fa1, wt1, nb2, len2, nd2, fa2, wt2;
    bit sp1, to1, sp2, to2;
    pulse_gate(3);
    fork
      recv_frame(fr1, nb1, len1, nd1, fa1, sp1, to1, wt1);
      begin
        repeat (3) @(posedge clk);
        pulse_gate(7);
        repeat (2) @(posedge clk);
        pulse_gate(9);
      end
    join
    recv_frame(fr2, nb2, len2, nd2, fa2, sp2, to2, wt2);
    if (fr1 !== 9'h003 || len1 !== 41) begin
      $display("FAIL ovr_first got=%h len=%0d expected=003 len=41", fr1, len1); failures++;
    end
    checks++;
    if (fr2 !== 9'h009 || to2 !== 1'b0) begin
      $display("FAIL ovr_second got=%h timeout=%0d expected=009", fr2, to2); failures++;
    end
    checks++;
    if (bus.overrun !== 1'b1) begin $display("FAIL ovr_flag got=%b expected=1", bus.overrun); failures++; end
    checks++;
    if (bus.leds !== 8'h09) begin $display("FAIL ovr_leds got=%h expected=09", bus.leds); failures++; end
    checks++;
  endtask

  task automatic test_reset_mid_frame;
    logic [8:0] fr;
    int nb, len, nd, fa, wt, bad;
    bit sp, to;
    wt = 0; bad = 0;
    pulse_gate(31);
    do begin
      @(negedge clk);
      wt++;
    end while (!bus.busy && wt < 200);
    repeat (19) @(negedge clk);
    if ({bus.busy, bus.frame_act, bus.sclk, bus.serout} !== 4'b1111) begin
      $display("FAIL mid_before got=%b expected=1111", {bus.busy, bus.frame_act, bus.sclk, bus.serout});
      failures++;
    end
    checks++;
    #2 reset = 1'b1;
    #1;
    if ({bus.serout, bus.sclk, bus.frame_act, bus.busy, bus.done} !== 5'b0) begin
      $display("FAIL mid_abort got=%b expected=00000",
               {bus.serout, bus.sclk, bus.frame_act, bus.busy, bus.done});
      failures++;
    end
    checks++;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) bad++;
    end
    if (bad !== 0) begin $display("FAIL mid_no_done got=%0d expected=0", bad); failures++; end
    checks++;
    if (bus.overrun !== 1'b0) begin $display("FAIL mid_overrun_cleared got=%b expected=0", bus.overrun); failures++; end
    checks++;
    pulse_gate(2);
    recv_frame(fr, nb, len, nd, fa, sp, to, wt);
    if (fr !== 9'h002 || nd !== 1) begin
      $display("FAIL mid_next_frame got=%h done=%0d expected=002 done=1", fr, nd); failures++;
    end
    checks++;
  endtask

  task automatic test_short_gate;
    logic [8:0] fr;
    int nb, len, nd, fa, wt;
    bit sp, to;
    pulse_gate(1);
    recv_frame(fr, nb, len, nd, fa, sp, to, wt);
    if (fr !== 9'h001 || len !== 41) begin
      $display("FAIL short_frame got=%h len=%0d expected=001 len=41", fr, len); failures++;
    end
    checks++;
  endtask

  task automatic test_fall_at_load;
    logic [8:0] fr1, fr2;
    int nb1, len1, nd1, fa1, wt1, nb2, len2, nd2, fa2, wt2;
    bit sp1, to1, sp2, to2;
    // Synchronised gate: high 4, low 1, high 1, low -> second fall lands in the LOAD cycle.
    @(posedge clk); #1 bus.ena = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.ena = 1'b0;
    @(posedge clk); #1 bus.ena = 1'b1;
    @(posedge clk); #1 bus.ena = 1'b0;
    recv_frame(fr1, nb1, len1, nd1, fa1, sp1, to1, wt1);
    recv_frame(fr2, nb2, len2, nd2, fa2, sp2, to2, wt2);
    if (fr1 !== 9'h004) begin $display("FAIL load_first got=%h expected=004", fr1); failures++; end
    checks++;
    if (fr2 !== 9'h001 || to2 !== 1'b0) begin
      $display("FAIL load_second got=%h timeout=%0d expected=001", fr2, to2); failures++;
    end
    checks++;
    if (wt2 !== 1) begin $display("FAIL load_idle_gap got=%0d expected=1", wt2); failures++; end
    checks++;
    if (bus.overrun !== 1'b0) begin $display("FAIL load_overrun got=%b expected=0", bus.overrun); failures++; end
    checks++;
    if (bus.leds !== 8'h01) begin $display("FAIL load_leds got=%h expected=01", bus.leds); failures++; end
    checks++;
  endtask

  initial begin
    bus.ena = 1'b0;
    test_reset();
    test_single_gate();
    test_saturation();
    test_overrun();
    test_reset_mid_frame();
    test_short_gate();
    test_fall_at_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
